// File: rtl/enc_pkg.sv
// Shared definitions for the sequential index encoder family.
//   enc_state_t : FSM states (IDLE waits for a vector, SCAN emits indices)
//   ENC_N       : default request-vector width
//   ENC_IDX_W   : default index width ($clog2(ENC_N))
//   popcount    : number of set bits in a vector of up to 32 bits
package enc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } enc_state_t;

    localparam int ENC_N     = 8;
    localparam int ENC_IDX_W = 3;

    // Callers zero-extend narrower vectors to 32 bits.
    function automatic logic [31:0] popcount(input logic [31:0] v);
        logic [31:0] acc;
        acc = '0;
        for (int i = 0; i < 32; i++) begin
            acc = acc + {31'd0, v[i]};
        end
        return acc;
    endfunction

endpackage

// File: rtl/prio_enc_comb.sv
// Combinational N -> IDX_W priority encoder.
// Ports:
//   req : request vector, bit i = request at index i
//   idx : index of the winning set bit (0 when req is all-zero)
// Direction: lowest set index wins by default; with macro ENC_MSB_FIRST_EN
// defined the highest set index wins.
module prio_enc_comb #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx
);

    // The loop runs away from the winning end so the last assignment made
    // is the highest-priority set bit.
    always_comb begin
        idx = '0;
`ifdef ENC_MSB_FIRST_EN
        for (int i = 0; i < N; i++) begin
            if (req[i]) idx = IDX_W'(i);
        end
`else
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = IDX_W'(i);
        end
`endif
    end

endmodule

// File: rtl/enc_8to3_seq.sv
// Sequential multi-hot to index serialiser (companion to the 3-to-8 decoder).
// A vector loaded in IDLE is emitted one set-bit index per out_valid/out_ready
// handshake, in priority order, then the block returns to IDLE.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   e          : block enable; low flushes the in-flight vector at the next edge
//   in_valid   : d_in presented
//   in_ready   : vector can be accepted (IDLE and enabled)
//   d_in       : N-bit request vector
//   out_valid  : d_out holds a valid index
//   out_ready  : consumer accepts d_out
//   d_out      : current highest-priority pending index
//   out_last   : d_out is the final pending bit of the vector
//   zero_flag  : one-cycle pulse after an all-zero vector is accepted
//   count      : number of pending bits
// Macro ENC_MSB_FIRST_EN selects highest-index-first priority.
module enc_8to3_seq
    import enc_pkg::*;
#(
    parameter int N     = ENC_N,
    parameter int IDX_W = ENC_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             e,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     d_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] d_out,
    output logic             out_last,
    output logic             zero_flag,
    output logic [IDX_W:0]   count
);

    localparam int CW = IDX_W + 1;

    generate
        if (IDX_W != $clog2(N)) begin : g_bad_idx_w
            $error("enc_8to3_seq: IDX_W must equal $clog2(N)");
        end
    endgenerate

    enc_state_t       state_reg, state_next;
    logic [N-1:0]     pending_reg, pending_next;
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic [IDX_W-1:0] d_out_reg;
    logic             out_last_reg;
    logic             zero_flag_reg, zero_flag_next;
    logic [IDX_W:0]   count_reg, count_next;
    logic [IDX_W-1:0] idx_next;

    // Outputs are registered from the next pending set, so after every edge
    // d_out/count/out_last already describe the pending bits left behind.
    prio_enc_comb #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_prio (
        .req (pending_next),
        .idx (idx_next)
    );

    always_comb begin
        pending_next   = pending_reg;
        state_next     = state_reg;
        zero_flag_next = 1'b0;
        if (!e) begin
            pending_next = '0;
            state_next   = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid && in_ready_reg) begin
                        if (d_in != '0) begin
                            pending_next = d_in;
                            state_next   = SCAN;
                        end else begin
                            zero_flag_next = 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (out_ready) begin
                        // d_out_reg always names the winning pending bit.
                        pending_next = pending_reg & ~(N'(1) << d_out_reg);
                        if (pending_next == '0) state_next = IDLE;
                    end
                end
                default: begin
                    pending_next = '0;
                    state_next   = IDLE;
                end
            endcase
        end
        count_next = CW'(popcount(32'(pending_next)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            pending_reg   <= '0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            d_out_reg     <= '0;
            out_last_reg  <= 1'b0;
            zero_flag_reg <= 1'b0;
            count_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            pending_reg   <= pending_next;
            in_ready_reg  <= e && (state_next == IDLE);
            out_valid_reg <= (state_next == SCAN);
            d_out_reg     <= idx_next;
            out_last_reg  <= (count_next == CW'(1));
            zero_flag_reg <= zero_flag_next;
            count_reg     <= count_next;
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign d_out     = d_out_reg;
    assign out_last  = out_last_reg;
    assign zero_flag = zero_flag_reg;
    assign count     = count_reg;

endmodule

// File: tb/tb_enc_8to3_seq.sv
module tb_enc_8to3_seq;

    localparam int N     = 8;
    localparam int IDX_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             e;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     d_in;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] d_out;
    logic             out_last;
    logic             zero_flag;
    logic [IDX_W:0]   count;

    int vectors     = 0;
    int miscompares = 0;

    enc_8to3_seq #(.N(N), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .e         (e),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d_in      (d_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d_out     (d_out),
        .out_last  (out_last),
        .zero_flag (zero_flag),
        .count     (count)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: the list of set indices in emission order.
    function automatic void expected_order(input logic [N-1:0] v, output int q[$]);
        q = {};
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
`ifdef ENC_MSB_FIRST_EN
                q.push_front(i);
`else
                q.push_back(i);
`endif
            end
        end
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, ".out_valid"}, int'(out_valid), 0);
        chk({tag, ".in_ready"}, int'(in_ready), 1);
        chk({tag, ".count"}, int'(count), 0);
    endtask

    // mode 0: always ready, 1: ready toggles 1,0,1,..., 2: random ready.
    // in_valid is held high with junk d_in during the scan; it must be ignored.
    task automatic run_vector(input logic [N-1:0] v, input int mode, input string tag);
        int q[$];
        int guard;
        bit rdy;
        expected_order(v, q);
        chk({tag, ".pre_in_ready"}, int'(in_ready), 1);
        in_valid = 1'b1;
        d_in     = v;
        out_ready = 1'b0;
        tick();
        if (v == '0) begin
            in_valid = 1'b0;
            chk({tag, ".zero_flag"}, int'(zero_flag), 1);
            check_idle({tag, ".zero"});
            tick();
            chk({tag, ".zero_flag_pulse"}, int'(zero_flag), 0);
            chk({tag, ".zero_out_valid"}, int'(out_valid), 0);
        end else begin
            chk({tag, ".zero_flag_nz"}, int'(zero_flag), 0);
            guard = 0;
            rdy   = 1'b1;
            while (q.size() > 0 && guard < 64) begin
                guard++;
                chk({tag, ".out_valid"}, int'(out_valid), 1);
                chk({tag, ".in_ready_scan"}, int'(in_ready), 0);
                chk({tag, ".d_out"}, int'(d_out), q[0]);
                chk({tag, ".count"}, int'(count), q.size());
                chk({tag, ".out_last"}, int'(out_last), int'(q.size() == 1));
                if (mode == 1)      rdy = (guard % 2) == 1;
                else if (mode == 2) rdy = $urandom_range(0, 1) == 1;
                else                rdy = 1'b1;
                out_ready = rdy;
                in_valid  = 1'b1;
                d_in      = N'($urandom);
                tick();
                if (rdy) void'(q.pop_front());
            end
            chk({tag, ".drained_in_budget"}, int'(q.size()), 0);
            in_valid  = 1'b0;
            out_ready = 1'b0;
            check_idle({tag, ".done"});
            chk({tag, ".out_last_idle"}, int'(out_last), 0);
        end
        $display("vector %s d_in=%08b mode=%0d vectors=%0d miscompares=%0d",
                 tag, v, mode, vectors, miscompares);
    endtask

    initial begin
        int first_idx;
        rst = 1'b1; e = 1'b1; in_valid = 1'b0; d_in = '0; out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst.in_ready", int'(in_ready), 0);
        chk("rst.out_valid", int'(out_valid), 0);
        chk("rst.d_out", int'(d_out), 0);
        chk("rst.out_last", int'(out_last), 0);
        chk("rst.zero_flag", int'(zero_flag), 0);
        chk("rst.count", int'(count), 0);
        rst = 1'b0;
        tick();
        chk("post_rst.in_ready", int'(in_ready), 1);

        // Directed vectors
        run_vector(8'b1010_0100, 0, "a4");
        run_vector(8'hFF, 1, "ff_stall");
        run_vector(8'h00, 0, "zero");

        // Enable drop mid-scan
        in_valid = 1'b1; d_in = 8'b0001_1000; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
`ifdef ENC_MSB_FIRST_EN
        first_idx = 4;
`else
        first_idx = 3;
`endif
        chk("flush.first_idx", int'(d_out), first_idx);
        chk("flush.first_count", int'(count), 2);
        tick();
        chk("flush.second_valid", int'(out_valid), 1);
        chk("flush.second_last", int'(out_last), 1);
        e = 1'b0;
        tick();
        chk("flush.out_valid", int'(out_valid), 0);
        chk("flush.count", int'(count), 0);
        chk("flush.in_ready_off", int'(in_ready), 0);
        e = 1'b1;
        tick();
        check_idle("flush.resume");
        tick();
        chk("flush.no_resume", int'(out_valid), 0);
        $display("vector flush d_in=00011000 vectors=%0d miscompares=%0d", vectors, miscompares);

        // Reset mid-scan
        in_valid = 1'b1; d_in = 8'hF0; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("rstmid.loaded", int'(out_valid), 1);
        tick();
        rst = 1'b1;
        tick();
        chk("rstmid.out_valid", int'(out_valid), 0);
        chk("rstmid.count", int'(count), 0);
        chk("rstmid.d_out", int'(d_out), 0);
        chk("rstmid.in_ready", int'(in_ready), 0);
        chk("rstmid.out_last", int'(out_last), 0);
        rst = 1'b0;
        tick();
        run_vector(8'h01, 0, "one");

        // Randomized vectors against the reference ordering
        for (int k = 0; k < 30; k++) begin
            logic [N-1:0] v;
            v = N'($urandom);
            if (k % 10 == 9) v = '0;
            run_vector(v, k % 3, $sformatf("rnd%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
